asrv32_fetch: RTL
=================

Name: asrv32_fetch

Overview:
Instruction-fetch stage of the ASRV32 core, directly upstream of asrv32_decoder. It owns the PC and issues word reads to instruction memory over a request/ack handshake. It presents each fetched instruction with its PC and a valid flag to the decoder's i_inst input. It absorbs downstream stalls with a one-entry buffer and handles PC redirects from branch/jump/trap logic.

Parameters:
PC_RESET, 32'h0000_0000, PC of the first fetch after reset
INST_NOP, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven on o_inst when not valid

Ports:
i_clk  in  1  core clock
i_rst_n  in  1  asynchronous active-low reset
o_iaddr  out  32  instruction memory word address, bits [1:0] always 0
o_rd_req  out  1  read request; address stable while high until i_ack
i_ack  in  1  memory response valid; i_inst valid this cycle
i_inst  in  32  instruction word from memory
o_inst  out  32  instruction to decoder
o_pc  out  32  PC of o_inst
o_valid  out  1  o_inst/o_pc hold a real instruction
i_stall  in  1  downstream cannot accept a new instruction this cycle
i_change_pc  in  1  redirect request, single-cycle pulse
i_new_pc  in  32  redirect target
o_misaligned  out  1  present only with FETCH_ALIGN_CHECK_EN

Behaviour:
- One clock (i_clk). Reset is asynchronous and active-low (i_rst_n). All state clears immediately on assertion.
- Reset values: o_iaddr=PC_RESET, o_rd_req=0, o_inst=INST_NOP, o_pc=PC_RESET, o_valid=0, buffer empty, discard flag 0, state START.
- States: START, REQ, HOLD.
- START: held for exactly one cycle after reset release, then moves to REQ with o_rd_req=1.
- REQ:
  - o_rd_req=1 and o_iaddr held stable until i_ack.
  - On i_ack with !i_stall: o_inst<=i_inst, o_pc<=o_iaddr, o_valid<=1, o_iaddr<=o_iaddr+4. Stay in REQ; back-to-back acks give one instruction per cycle.
  - On i_ack with i_stall: capture i_inst/o_iaddr into the buffer, o_iaddr<=o_iaddr+4, o_rd_req<=0, go to HOLD.
  - No i_ack and !i_stall: o_valid<=0, o_inst<=INST_NOP.
  - No i_ack and i_stall: outputs hold.
- HOLD:
  - o_rd_req=0. o_inst/o_pc/o_valid hold while i_stall=1.
  - First cycle with i_stall=0: the buffer moves to the outputs (o_valid=1), the buffer empties, go to REQ. The next request issues in that same cycle.
- Stall rule: while i_stall=1, o_inst/o_pc/o_valid never change, except on redirect.
- Redirect (i_change_pc=1) has highest priority in every state, including the same cycle as i_ack or i_stall:
  - o_iaddr<={i_new_pc[31:2],2'b00}; o_valid<=0; o_inst<=INST_NOP; buffer cleared.
  - Any i_ack in the same cycle is dropped.
  - If a request was outstanding and not acked, set the discard flag; the next i_ack is ignored and clears the flag.
  - Go to REQ and request the new address on the following cycle.
- Memory contract: at most one outstanding request; i_ack is only legal while a request is outstanding (o_rd_req=1, or discard pending).
- Wrap-around: o_iaddr 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- Reset mid-transaction: the pending request is abandoned; any i_ack arriving in START is ignored.

Optional Feature:
FETCH_ALIGN_CHECK_EN:
- Defined: adds o_misaligned (reset 0). When a redirect has i_new_pc[1:0]!=0, o_misaligned=1 from the next cycle, o_rd_req stays 0 and the block parks until the next redirect or reset. The fetch address is the unmasked i_new_pc.
- Undefined: no port; bits [1:0] are silently masked to zero.

Test Plan:
- Reset release, memory acks every cycle with i_inst=0x00A00093,0x00100113,… -> first request at 0x0, o_valid=1 one cycle after the first ack, o_pc sequence 0x0,0x4,0x8.
- Assert i_stall for 3 cycles during an ack of 0x00208133 at PC 0x8 -> outputs frozen on the PC 0x4 instruction, o_rd_req=0, then o_inst=0x00208133 with o_pc=0x8 on the first unstalled cycle, and the next request goes to 0xC.
- Redirect to 0x100 in the same cycle as an ack for PC 0x10 -> ack dropped, o_valid=0, next o_iaddr=0x100, first valid o_pc=0x100.
- Redirect to 0x200 while a request to 0x14 is outstanding, with ack 2 cycles later -> that ack is discarded, the next request goes to 0x200, and o_pc never shows 0x14.
- Redirect to 0xFFFF_FFFC, then two acks -> o_pc 0xFFFF_FFFC then 0x0000_0000.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x102 -> o_misaligned=1 and o_rd_req stays 0; a later redirect to 0x200 clears it and fetch resumes. Without the macro -> fetch goes to 0x100.

Source files
------------

// File: rtl/asrv32_fetch.sv
// ASRV32 instruction-fetch stage: owns the PC, fetches words over a request/ack handshake and
// absorbs one stalled instruction in a buffer. Optional macro FETCH_ALIGN_CHECK_EN parks on misaligned redirects.
module asrv32_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_iaddr,
    output logic        o_rd_req,
    input  logic        i_ack,
    input  logic [31:0] i_inst,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_valid,
    input  logic        i_stall,
    input  logic        i_change_pc,
    input  logic [31:0] i_new_pc
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        o_misaligned
`endif
);

    typedef enum logic [1:0] {
        ST_START,
        ST_REQ,
        ST_HOLD
    } state_e;

    state_e      state_q;
    logic [31:0] iaddr_q;
    logic [31:0] inst_q;
    logic [31:0] pc_q;
    logic [31:0] buf_inst_q;
    logic [31:0] buf_pc_q;
    logic        rd_req_q;
    logic        valid_q;
    logic        discard_q;

    logic [31:0] iaddr_inc_d;
    logic [31:0] redirect_pc_d;
    logic        redirect_req_d;
    logic        ack_take_d;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        misaligned_q;
    logic        misalign_d;
`endif

    always_comb begin
        iaddr_inc_d = iaddr_q + 32'd4;
        // An ack only counts while our own request is live; a discarded one is swallowed.
        ack_take_d  = i_ack && (state_q == ST_REQ) && rd_req_q && !discard_q;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_d     = (i_new_pc[1:0] != 2'b00);
        redirect_pc_d  = i_new_pc;
        redirect_req_d = !misalign_d;
`else
        redirect_pc_d  = i_new_pc & 32'hFFFF_FFFC;
        redirect_req_d = 1'b1;
`endif
    end

    // NOTE: every register here uses <= so all next-state terms read the pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_START;
            iaddr_q    <= PC_RESET;
            rd_req_q   <= 1'b0;
            inst_q     <= INST_NOP;
            pc_q       <= PC_RESET;
            valid_q    <= 1'b0;
            discard_q  <= 1'b0;
            // NOTE: the one-entry buffer is reset too, so no X can ever reach the decoder.
            buf_inst_q <= INST_NOP;
            buf_pc_q   <= PC_RESET;
`ifdef FETCH_ALIGN_CHECK_EN
            misaligned_q <= 1'b0;
`endif
        end else if (i_change_pc) begin
            state_q    <= ST_REQ;
            iaddr_q    <= redirect_pc_d;
            rd_req_q   <= redirect_req_d;
            valid_q    <= 1'b0;
            inst_q     <= INST_NOP;
            buf_inst_q <= INST_NOP;
            discard_q  <= (rd_req_q || discard_q) && !i_ack;
`ifdef FETCH_ALIGN_CHECK_EN
            misaligned_q <= misalign_d;
`endif
        end else begin
            case (state_q)
                ST_START: begin
                    state_q  <= ST_REQ;
                    rd_req_q <= 1'b1;
                end
                ST_REQ: begin
                    if (i_ack && discard_q) begin
                        discard_q <= 1'b0;
                    end
                    if (ack_take_d) begin
                        iaddr_q <= iaddr_inc_d;
                        if (i_stall) begin
                            buf_inst_q <= i_inst;
                            buf_pc_q   <= iaddr_q;
                            rd_req_q   <= 1'b0;
                            state_q    <= ST_HOLD;
                        end else begin
                            inst_q  <= i_inst;
                            pc_q    <= iaddr_q;
                            valid_q <= 1'b1;
                        end
                    end else if (!i_stall) begin
                        valid_q <= 1'b0;
                        inst_q  <= INST_NOP;
                    end
                end
                ST_HOLD: begin
                    if (!i_stall) begin
                        inst_q   <= buf_inst_q;
                        pc_q     <= buf_pc_q;
                        valid_q  <= 1'b1;
                        rd_req_q <= 1'b1;
                        state_q  <= ST_REQ;
                    end
                end
                default: state_q <= ST_START;
            endcase
        end
    end

    assign o_iaddr  = iaddr_q;
    assign o_rd_req = rd_req_q;
    assign o_inst   = inst_q;
    assign o_pc     = pc_q;
    assign o_valid  = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign o_misaligned = misaligned_q;
`endif

endmodule
